// File: rtl/rr_bus_arbiter_pkg.sv
// rr_bus_arbiter_pkg: shared state encoding and width helper for the round-robin arbiter
package rr_bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OFFER = 2'd1, WAIT = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r < 1 ? 1 : r;
  endfunction
endpackage

// File: rtl/rr_bus_arbiter_parallel_mux.sv
// parallel_mux: one-hot AND-OR payload select, all-zero select yields zero
module parallel_mux #(
  parameter int WIDTH = 32,
  parameter int MUX_QUANTITY = 4
) (
  input  logic [MUX_QUANTITY-1:0]       sel,
  input  logic [WIDTH*MUX_QUANTITY-1:0] data,
  output logic [WIDTH-1:0]              out
);
  // OR together every payload gated by its select bit
  always_comb begin
    out = '0;
    for (int i = 0; i < MUX_QUANTITY; i++) out = out | (data[i*WIDTH +: WIDTH] & {WIDTH{sel[i]}});
  end
endmodule

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin grant of one shared resource with ready/done handshake and watchdog
module rr_bus_arbiter
  import rr_bus_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REQ_QUANTITY = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REQ_QUANTITY-1:0]       req,
  input  logic [WIDTH*REQ_QUANTITY-1:0] req_data,
  output logic [REQ_QUANTITY-1:0]       grant,
  output logic [WIDTH-1:0]              sel_data,
  output logic                          res_valid,
  input  logic                          res_ready,
  input  logic                          res_done,
  output logic                          busy,
  output logic                          timeout
);
  localparam int PW = clog2(REQ_QUANTITY);
  localparam int CW = clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [PW-1:0] PMAX = PW'(REQ_QUANTITY - 1);
  localparam logic [REQ_QUANTITY-1:0] ONE = REQ_QUANTITY'(1);
  state_t state, state_n;
  logic [REQ_QUANTITY-1:0] grant_n, mask, masked, cand, pick;
  logic [PW-1:0] ptr, ptr_n, idx;
  logic [CW-1:0] cnt, cnt_n;
  logic done, expire, timeout_n;
  // requesters at or above the pointer get first pick; otherwise wrap to the lowest
  for (genvar g = 0; g < REQ_QUANTITY; g++) begin : g_mask
    assign mask[g] = PW'(g) >= ptr;
  end
  assign masked = req & mask;
  assign cand = |masked ? masked : req;
  assign pick = cand & (~cand + ONE);
  assign done = state == OFFER ? (res_ready & res_done) : ((state == WAIT) & res_done);
  assign expire = (TIMEOUT_CYCLES > 0) && (state != IDLE) && (cnt == LAST);
  // index of the current owner, used to advance the pointer past it
  always_comb begin
    idx = '0;
    for (int i = 0; i < REQ_QUANTITY; i++) idx = grant[i] ? PW'(i) : idx;
  end
  // next-state: arbitrate in IDLE, hold through the handshake, release on done or expiry
  always_comb begin
    state_n = state;
    grant_n = grant;
    ptr_n = ptr;
    timeout_n = 1'b0;
    cnt_n = (state == IDLE || TIMEOUT_CYCLES == 0) ? '0 : cnt + CW'(1);
    if (state == IDLE) begin
      if (|req) begin
        state_n = OFFER;
        grant_n = pick;
      end
    end else if (done || expire) begin
      state_n = IDLE;
      grant_n = '0;
      ptr_n = idx == PMAX ? '0 : idx + PW'(1);
      timeout_n = !done;
    end else if (state == OFFER && res_ready) begin
      state_n = WAIT;
    end
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      res_valid <= 1'b0;
      busy <= 1'b0;
      timeout <= 1'b0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      res_valid <= state_n == OFFER;
      busy <= state_n != IDLE;
      timeout <= timeout_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
    end
  end
  parallel_mux #(.WIDTH(WIDTH), .MUX_QUANTITY(REQ_QUANTITY)) u_mux (
    .sel(grant),
    .data(req_data),
    .out(sel_data)
  );
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb_rr_bus_arbiter: directed plan steps plus random traffic against a behavioural model
module tb_rr_bus_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [W*N-1:0] req_data = '0;
  logic [N-1:0] grant;
  logic [W-1:0] sel_data;
  logic res_valid, res_ready = 1'b0, res_done = 1'b0, busy, timeout;
  int checks = 0;
  int failures = 0;
  int m_owner = -1;
  bit m_offer = 0;
  int m_age = 0;
  int m_ptr = 0;
  bit m_to = 0;
  rr_bus_arbiter #(.WIDTH(W), .REQ_QUANTITY(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant),
    .sel_data(sel_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_done(res_done), .busy(busy), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_step();
    bit fin;
    m_to = 0;
    if (rst) begin
      m_owner = -1; m_offer = 0; m_age = 0; m_ptr = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
      if (m_owner >= 0) begin
        m_offer = 1; m_age = 0;
      end
    end else begin
      fin = m_offer ? (res_ready && res_done) : res_done;
      if (fin || m_age == TO - 1) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_offer = 0; m_to = !fin;
      end else begin
        if (m_offer && res_ready) m_offer = 0;
        m_age++;
      end
    end
  endtask
  task automatic check_model();
    logic [31:0] eg, es;
    eg = m_owner < 0 ? 32'd0 : 32'd1 << m_owner;
    es = m_owner < 0 ? 32'd0 : req_data[m_owner*W +: W];
    chk("m_grant", 32'(grant), eg);
    chk("m_sel_data", sel_data, es);
    chk("m_res_valid", 32'(res_valid), 32'(m_offer));
    chk("m_busy", 32'(busy), 32'(m_owner >= 0));
    chk("m_timeout", 32'(timeout), 32'(m_to));
  endtask
  task automatic cyc(input logic [N-1:0] r, input logic rdy, input logic dn, input logic rs);
    req = r; res_ready = rdy; res_done = dn; rst = rs;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask
  initial begin
    req_data = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    cyc('0, 0, 0, 1);
    cyc('0, 0, 0, 1);
    chk("reset_grant", 32'(grant), 0);
    chk("reset_busy", 32'(busy), 0);
    req_data[95:64] = 32'hDEADBEEF;
    cyc(4'b0100, 0, 0, 0);
    chk("single_grant", 32'(grant), 32'b0100);
    chk("single_sel", sel_data, 32'hDEADBEEF);
    chk("single_valid", 32'(res_valid), 1);
    cyc('0, 1, 0, 0);
    chk("single_ready_valid", 32'(res_valid), 0);
    chk("single_wait_grant", 32'(grant), 32'b0100);
    cyc('0, 0, 1, 0);
    chk("single_done_grant", 32'(grant), 0);
    cyc(4'b0011, 0, 0, 0);
    chk("wrap_grant0", 32'(grant), 32'b0001);
    cyc(4'b0011, 1, 1, 0);
    cyc(4'b0011, 0, 0, 0);
    chk("wrap_grant1", 32'(grant), 32'b0010);
    cyc('0, 1, 1, 0);
    cyc('0, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(4'b1111, 0, 0, 0);
      chk("fair_grant", 32'(grant), 32'd1 << (k % N));
      cyc(4'b1111, 1, 1, 0);
      chk("fair_idle_gap", 32'(grant), 0);
    end
    cyc(4'b1111, 0, 0, 0);
    chk("both_grant", 32'(grant), 32'b0010);
    cyc(4'b1111, 0, 1, 0);
    chk("done_no_ready_grant", 32'(grant), 32'b0010);
    chk("done_no_ready_valid", 32'(res_valid), 1);
    cyc(4'b1111, 1, 1, 0);
    chk("both_release", 32'(grant), 0);
    chk("both_busy", 32'(busy), 0);
    cyc(4'b0100, 0, 0, 0);
    chk("to_grant", 32'(grant), 32'b0100);
    for (int k = 1; k < TO; k++) begin
      cyc('0, 1, 0, 0);
      chk("to_hold", 32'(grant), 32'b0100);
    end
    cyc('0, 1, 0, 0);
    chk("to_pulse", 32'(timeout), 1);
    chk("to_release", 32'(grant), 0);
    chk("to_busy", 32'(busy), 0);
    cyc('0, 0, 0, 0);
    chk("to_pulse_end", 32'(timeout), 0);
    cyc(4'b1111, 0, 0, 0);
    chk("to2_grant", 32'(grant), 32'b1000);
    for (int k = 1; k < TO; k++) cyc('0, 1, 0, 0);
    cyc('0, 0, 1, 0);
    chk("to2_no_pulse", 32'(timeout), 0);
    chk("to2_release", 32'(grant), 0);
    cyc(4'b0010, 0, 0, 0);
    chk("rst_pre_grant", 32'(grant), 32'b0010);
    cyc('0, 1, 0, 0);
    cyc('0, 0, 0, 1);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    cyc(4'b1111, 0, 0, 0);
    chk("rst_ptr_grant", 32'(grant), 32'b0001);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) req_data = {$urandom, $urandom, $urandom, $urandom};
      cyc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
          $urandom_range(0, 99) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
